// File: rtl/edu_token_scheduler_pkg.sv
// Shared definitions for the EDU token scheduler slice.
//  - Array geometry used to derive the default number of scanned token lines.
//  - Scheduler state encoding.
package edu_token_scheduler_pkg;

  // Micro-cell array geometry of the fast-sliding path.
  localparam int unsigned NUM_UCROW = 4;
  localparam int unsigned NUM_UCCOL = 4;

  // One token line per row/column diagonal pair.
  localparam int unsigned DEF_NUM_LINES = 2 * NUM_UCROW + 2 * NUM_UCCOL - 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

endpackage

// File: rtl/edu_token_scheduler_prio_enc.sv
// Combinational rotated priority encoder.
// Finds the first set bit of vec, searching upward from start_idx and wrapping
// around to 0. start_idx must be below NUM_LINES.
//  vec        in   NUM_LINES  request vector
//  start_idx  in   IDX_W      first position searched
//  onehot     out  NUM_LINES  one-hot of the selected position (0 if none)
//  idx        out  IDX_W      selected position (0 if none)
//  any        out  1          at least one bit of vec is set
module edu_token_prio_enc #(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IDX_W     = 4
) (
  input  logic [NUM_LINES-1:0] vec,
  input  logic [IDX_W-1:0]     start_idx,
  output logic [NUM_LINES-1:0] onehot,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  int unsigned          pos;
  logic [NUM_LINES-1:0] vec_sh;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    vec_sh = '0;
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      pos = 32'(start_idx) + k;
      if (pos >= NUM_LINES) begin
        pos = pos - NUM_LINES;
      end
      vec_sh = vec >> pos;
      if (!any && vec_sh[0]) begin
        any    = 1'b1;
        idx    = IDX_W'(pos);
        onehot = NUM_LINES'(1) << pos;
      end
    end
  end

endmodule

// File: rtl/edu_token_scheduler.sv
// EDU token scheduler: captures a token-exist vector over all scan lines and
// issues one token line per grant handshake until the vector is drained.
//  clk           in   1          clock
//  rst_n         in   1          asynchronous reset, active low
//  flush         in   1          synchronous abort of the current batch
//  load_valid    in   1          new token vector offered
//  load_ready    out  1          scheduler idle, can accept a vector
//  load_vec      in   NUM_LINES  token-exist bit per line
//  grant_valid   out  1          a token line is presented
//  grant_ready   in   1          consumer takes the presented line
//  grant_onehot  out  NUM_LINES  one-hot of the presented line
//  grant_idx     out  IDX_W      index of the presented line
//  token_cnt     out  IDX_W      popcount of the vector captured at load
//  batch_done    out  1          one-cycle pulse: batch fully drained
// RR_MODE = 0 grants lowest index first; RR_MODE = 1 searches round-robin
// from the line after the last grant (last grant persists across batches).
module edu_token_scheduler
  import edu_token_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LINES = DEF_NUM_LINES,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES) + 1,
  parameter int unsigned RR_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [NUM_LINES-1:0] load_vec,
  output logic                 grant_valid,
  input  logic                 grant_ready,
  output logic [NUM_LINES-1:0] grant_onehot,
  output logic [IDX_W-1:0]     grant_idx,
  output logic [IDX_W-1:0]     token_cnt,
  output logic                 batch_done
);

  localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(NUM_LINES - 1);

  sched_state_e         state_q, state_d;
  logic [NUM_LINES-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;

  logic [IDX_W-1:0]     start_idx;
  logic [NUM_LINES-1:0] enc_onehot;
  logic [IDX_W-1:0]     enc_idx;
  logic                 enc_any;
  logic [IDX_W-1:0]     load_popcnt;
  logic                 busy;

  // Search starts one past the last grant, wrapping at the top line.
  assign start_idx = (RR_MODE == 0) ? '0 :
                     (last_q == LAST_LINE) ? '0 : last_q + 1'b1;

  edu_token_prio_enc #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_prio_enc (
    .vec       (pending_q),
    .start_idx (start_idx),
    .onehot    (enc_onehot),
    .idx       (enc_idx),
    .any       (enc_any)
  );

  always_comb begin
    load_popcnt = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      load_popcnt = load_popcnt + IDX_W'(load_vec[i]);
    end
  end

  // Outputs depend only on registered state; pending is never empty in BUSY.
  assign busy         = (state_q == BUSY) && enc_any;
  assign load_ready   = (state_q == IDLE);
  assign grant_valid  = busy;
  assign grant_onehot = busy ? enc_onehot : '0;
  assign grant_idx    = busy ? enc_idx : '0;
  assign token_cnt    = cnt_q;
  assign batch_done   = done_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            pending_d = load_vec;
            cnt_d     = load_popcnt;
            if (load_vec == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          if (grant_ready) begin
            pending_d = pending_q & ~enc_onehot;
            last_d    = enc_idx;
            if (pending_d == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      last_q    <= LAST_LINE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

endmodule
